// File: rtl/mem_bridge_if.sv
// CPU-side byte-addressed bus of the memory bridge: request fields plus the
// registered-latency read word returning to the CPU.
interface mem_bridge_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] addr;
   logic                  wr;
   logic                  byt;
   logic [15:0]           wr_data;
   logic [15:0]           rd_data;

   // Single-cycle request bus with no valid/ready: a request is taken on every
   // rising clk edge, and rd_data for it is valid throughout the following cycle.
   modport master (
      output addr, wr, byt, wr_data,
      input  rd_data
   );

   modport slave (
      input  addr, wr, byt, wr_data,
      output rd_data
   );
endinterface

// File: rtl/mem_bridge.sv
// 16-bit CPU bus to two 8-bit synchronous RAM banks (lo = even bytes, hi = odd).
// Optional macro MEM_UNALIGNED_EN enables word accesses at odd byte addresses.
module mem_bridge #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_bridge_if.slave           cpu,
   output logic                  bram_clk,
   output logic                  bram_rst,
   output logic                  wr_lo,
   output logic                  wr_hi,
   output logic [ADDR_WIDTH-2:0] addr_lo,
   output logic [ADDR_WIDTH-2:0] addr_hi,
   output logic [7:0]            wr_data_lo,
   output logic [7:0]            wr_data_hi,
   input  logic [7:0]            rd_data_lo,
   input  logic [7:0]            rd_data_hi
);
   localparam int BW = ADDR_WIDTH - 1;

   logic [BW-1:0] w;
   logic          odd;
   logic          byt_q;
   logic          odd_q;

   assign w        = cpu.addr[ADDR_WIDTH-1:1];
   assign odd      = cpu.addr[0];
   assign bram_clk = clk;
   assign bram_rst = rst;

   always_comb begin
      addr_lo    = w;
      addr_hi    = w;
      wr_data_lo = cpu.wr_data[7:0];
      wr_data_hi = cpu.wr_data[15:8];
      wr_lo      = cpu.wr;
      wr_hi      = cpu.wr;
      if (cpu.byt) begin
         // Byte data always rides on the low lane; only one strobe fires.
         wr_data_hi = cpu.wr_data[7:0];
         wr_lo      = cpu.wr & ~odd;
         wr_hi      = cpu.wr & odd;
      end
`ifdef MEM_UNALIGNED_EN
      else if (odd) begin
         addr_lo    = w + BW'(1);
         wr_data_hi = cpu.wr_data[7:0];
         wr_data_lo = cpu.wr_data[15:8];
      end
`endif
      if (rst) begin
         wr_lo = 1'b0;
         wr_hi = 1'b0;
      end
   end

   // Access shape is carried one cycle to line up with the registered bank data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byt_q <= 1'b0;
         odd_q <= 1'b0;
      end else begin
         byt_q <= cpu.byt;
         odd_q <= odd;
      end
   end

   always_comb begin
      cpu.rd_data = {rd_data_hi, rd_data_lo};
      if (byt_q) begin
         cpu.rd_data = {8'h00, (odd_q ? rd_data_hi : rd_data_lo)};
      end
`ifdef MEM_UNALIGNED_EN
      else if (odd_q) begin
         cpu.rd_data = {rd_data_lo, rd_data_hi};
      end
`endif
   end
endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with behavioural 8-bit bank models on both lanes.
// Covers MEM_UNALIGNED_EN when the macro is defined for the build.
module tb_mem_bridge;
   localparam int AW = 16;
   localparam int BW = AW - 1;

   logic          clk;
   logic          rst;
   logic          bram_clk;
   logic          bram_rst;
   logic          wr_lo;
   logic          wr_hi;
   logic [BW-1:0] addr_lo;
   logic [BW-1:0] addr_hi;
   logic [7:0]    wr_data_lo;
   logic [7:0]    wr_data_hi;
   logic [7:0]    rd_data_lo;
   logic [7:0]    rd_data_hi;

   logic [7:0] lo_mem [0:(1<<BW)-1];
   logic [7:0] hi_mem [0:(1<<BW)-1];

   int tests_run;
   int tests_failed;

   mem_bridge_if #(.ADDR_WIDTH(AW)) cpu_bus ();

   mem_bridge #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu        (cpu_bus.slave),
      .bram_clk   (bram_clk),
      .bram_rst   (bram_rst),
      .wr_lo      (wr_lo),
      .wr_hi      (wr_hi),
      .addr_lo    (addr_lo),
      .addr_hi    (addr_hi),
      .wr_data_lo (wr_data_lo),
      .wr_data_hi (wr_data_hi),
      .rd_data_lo (rd_data_lo),
      .rd_data_hi (rd_data_hi)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // bank models: registered read, read-before-write, zero output in reset
   always @(posedge bram_clk or posedge bram_rst) begin
      if (bram_rst) begin
         rd_data_lo <= 8'h00;
         rd_data_hi <= 8'h00;
      end else begin
         rd_data_lo <= lo_mem[addr_lo];
         rd_data_hi <= hi_mem[addr_hi];
         if (wr_lo) lo_mem[addr_lo] <= wr_data_lo;
         if (wr_hi) hi_mem[addr_hi] <= wr_data_hi;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver: present a request just after the falling edge
   task automatic drive(input logic [AW-1:0] a, input logic w, input logic b,
                        input logic [15:0] d);
      @(negedge clk);
      cpu_bus.addr    = a;
      cpu_bus.wr      = w;
      cpu_bus.byt     = b;
      cpu_bus.wr_data = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1;
      cpu_bus.addr    = '0;
      cpu_bus.wr      = 1'b0;
      cpu_bus.byt     = 1'b0;
      cpu_bus.wr_data = '0;
      for (int i = 0; i < (1<<BW); i++) begin
         lo_mem[i] = 8'h00;
         hi_mem[i] = 8'h00;
      end
      lo_mem[15'h180] = 8'h34;
      hi_mem[15'h180] = 8'h12;
      lo_mem[15'h040] = 8'h5A;
      hi_mem[15'h041] = 8'hC3;

      // reset state: strobes suppressed even with a write requested
      tick();
      drive(16'h0010, 1'b1, 1'b0, 16'hDEAD);
      check("rst_wr_lo", wr_lo, 0);
      check("rst_wr_hi", wr_hi, 0);
      check("rst_rd_data", cpu_bus.rd_data, 16'h0000);
      check("rst_bram_rst", bram_rst, 1);
      tick();
      @(negedge clk);
      rst = 1'b0;

      // aligned word read of preloaded data
      drive(16'h0300, 1'b0, 1'b0, 16'h0000);
      check("wrd_rd_addr_lo", addr_lo, 15'h180);
      check("wrd_rd_addr_hi", addr_hi, 15'h180);
      check("wrd_rd_first_cycle", cpu_bus.rd_data, 16'h0000);
      tick();
      check("wrd_rd_0300", cpu_bus.rd_data, 16'h1234);

      // even byte write goes to lo bank only
      drive(16'h0082, 1'b1, 1'b1, 16'h99AB);
      check("bwe_wr_lo", wr_lo, 1);
      check("bwe_wr_hi", wr_hi, 0);
      check("bwe_addr_lo", addr_lo, 15'h041);
      check("bwe_addr_hi", addr_hi, 15'h041);
      check("bwe_data_lo", wr_data_lo, 8'hAB);
      tick();
      drive(16'h0082, 1'b0, 1'b1, 16'h0000);
      tick();
      check("brd_0082", cpu_bus.rd_data, 16'h00AB);
      drive(16'h0080, 1'b0, 1'b1, 16'h0000);
      tick();
      check("brd_0080_untouched", cpu_bus.rd_data, 16'h005A);
      drive(16'h0082, 1'b0, 1'b0, 16'h0000);
      tick();
      check("wrd_0082_hi_kept", cpu_bus.rd_data, 16'hC3AB);

      // odd byte write: data from low lane, hi strobe only
      drive(16'h0083, 1'b1, 1'b1, 16'h117E);
      check("bwo_wr_lo", wr_lo, 0);
      check("bwo_wr_hi", wr_hi, 1);
      check("bwo_data_hi", wr_data_hi, 8'h7E);
      tick();
      drive(16'h0082, 1'b0, 1'b0, 16'h0000);
      tick();
      check("wrd_0082_after_odd", cpu_bus.rd_data, 16'h7EAB);

      // aligned word write
      drive(16'h0010, 1'b1, 1'b0, 16'hBEEF);
      check("ww_wr_lo", wr_lo, 1);
      check("ww_wr_hi", wr_hi, 1);
      check("ww_data_lo", wr_data_lo, 8'hEF);
      check("ww_data_hi", wr_data_hi, 8'hBE);
      check("ww_addr_lo", addr_lo, 15'h008);
      tick();
      drive(16'h0010, 1'b0, 1'b1, 16'h0000);
      tick();
      check("brd_0010", cpu_bus.rd_data, 16'h00EF);
      drive(16'h0011, 1'b0, 1'b1, 16'h0000);
      tick();
      check("brd_0011", cpu_bus.rd_data, 16'h00BE);

      // back-to-back alternation of byte/word reads
      for (int k = 0; k < 2; k++) begin
         drive(16'h0011, 1'b0, 1'b1, 16'h0000);
         tick();
         check("alt_byte_0011", cpu_bus.rd_data, 16'h00BE);
         drive(16'h0010, 1'b0, 1'b0, 16'h0000);
         tick();
         check("alt_word_0010", cpu_bus.rd_data, 16'hBEEF);
      end

      // write with read at same address returns old contents
      drive(16'h0010, 1'b1, 1'b0, 16'h1357);
      tick();
      check("rbw_old", cpu_bus.rd_data, 16'hBEEF);
      drive(16'h0010, 1'b0, 1'b0, 16'h0000);
      tick();
      check("rbw_new", cpu_bus.rd_data, 16'h1357);

      // reset asserted during a write aborts it
      drive(16'h0010, 1'b1, 1'b0, 16'hFFFF);
      rst = 1'b1;
      #1;
      check("mid_rst_wr_lo", wr_lo, 0);
      check("mid_rst_wr_hi", wr_hi, 0);
      check("mid_rst_rd_data", cpu_bus.rd_data, 16'h0000);
      tick();
      check("mid_rst_rd_edge", cpu_bus.rd_data, 16'h0000);
      drive(16'h0010, 1'b0, 1'b0, 16'h0000);
      rst = 1'b0;
      #1;
      check("post_rst_first", cpu_bus.rd_data, 16'h0000);
      tick();
      check("post_rst_mem_kept", cpu_bus.rd_data, 16'h1357);

`ifdef MEM_UNALIGNED_EN
      // unaligned word write/read
      drive(16'h0021, 1'b1, 1'b0, 16'h5678);
      check("uw_addr_hi", addr_hi, 15'h010);
      check("uw_addr_lo", addr_lo, 15'h011);
      check("uw_data_hi", wr_data_hi, 8'h78);
      check("uw_data_lo", wr_data_lo, 8'h56);
      check("uw_wr_both", {wr_hi, wr_lo}, 2'b11);
      tick();
      check("uw_mem_hi", hi_mem[15'h010], 8'h78);
      check("uw_mem_lo", lo_mem[15'h011], 8'h56);
      drive(16'h0021, 1'b0, 1'b0, 16'h0000);
      tick();
      check("uw_rd_0021", cpu_bus.rd_data, 16'h5678);
      drive(16'h0022, 1'b0, 1'b1, 16'h0000);
      tick();
      check("uw_brd_0022", cpu_bus.rd_data, 16'h0056);
      drive(16'hFFFF, 1'b0, 1'b0, 16'h0000);
      check("uw_wrap_addr_lo", addr_lo, 15'h0000);
      check("uw_wrap_addr_hi", addr_hi, 15'h7FFF);
`else
      // odd word address treated as aligned
      drive(16'h0021, 1'b1, 1'b0, 16'h5678);
      check("ow_addr_hi", addr_hi, 15'h010);
      check("ow_addr_lo", addr_lo, 15'h010);
      check("ow_data_lo", wr_data_lo, 8'h78);
      check("ow_data_hi", wr_data_hi, 8'h56);
      tick();
      check("ow_mem_lo", lo_mem[15'h010], 8'h78);
      check("ow_mem_hi", hi_mem[15'h010], 8'h56);
      drive(16'h0021, 1'b0, 1'b0, 16'h0000);
      tick();
      check("ow_rd_0021", cpu_bus.rd_data, 16'h5678);
      drive(16'h0020, 1'b0, 1'b1, 16'h0000);
      tick();
      check("ow_brd_0020", cpu_bus.rd_data, 16'h0078);
      drive(16'hFFFF, 1'b0, 1'b0, 16'h0000);
      check("ow_top_addr_lo", addr_lo, 15'h7FFF);
`endif

      drive(16'h0000, 1'b0, 1'b0, 16'h0000);
      tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
